fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//   Instruction-fetch sequencer for the 4004 core. Generates the 8-state machine
//   cycle (0=A1 .. 7=X3), holds the 12-bit program counter and the 3-level
//   address stack, and drives addr/cycle into the ROM.
//   Captures the ROM nibble stream (OPR at cycle 3, OPA at cycle 4) and hands
//   1- or 2-word instructions to the decoder.
// PARAMETERS
//   ADDR_W      12  program-counter / ROM address width
//   STACK_DEPTH 3   return-address stack entries (circular)
//   RESET_PC    0   PC value loaded on reset
// PORTS
//   clk           in   1       system clock, all state on rising edge
//   rst           in   1       asynchronous, active-high reset
//   nibble        in   4       ROM data nibble (valid in cycles 3 and 4)
//   two_byte      in   1       decoder: current first word needs a second word (sampled cycle 5)
//   pc_load       in   1       decoder: load PC from load_addr (sampled cycle 7)
//   load_addr     in   ADDR_W  jump/call target
//   push          in   1       decoder: with pc_load, push return address (JMS)
//   pop           in   1       decoder: PC <= stack top (BBL), sampled cycle 7
//   addr          out  ADDR_W  ROM address = PC, constant for a whole frame
//   cycle         out  3       machine cycle counter
//   sync          out  1       high while cycle==0
//   opr, opa      out  4 each  first instruction word
//   arg_hi,arg_lo out  4 each  second instruction word
//   word2         out  1       current frame fetches a second word
//   word_valid    out  1       one-clock pulse in cycle 5 of every frame
//   stack_err     out  1       sticky stack overflow/underflow (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (async): cycle=0, PC=RESET_PC, stack entries=0, ptr=0, opr/opa/arg=0,
//     word2=0, word_valid=0, stack_err=0. First frame starts on the first clk after release.
//   - cycle increments every clk, wraps 7->0; no stall.
//   - addr is registered PC. It changes only on the 7->0 edge.
//   - Nibble capture on the clock ending the cycle:
//     - cycle 3: nibble -> opr (word2=0) or arg_hi (word2=1).
//     - cycle 4: nibble -> opa (word2=0) or arg_lo (word2=1).
//     - opr/opa are held through the second frame.
//   - word_valid=1 exactly while cycle==5. two_byte is sampled at the end of cycle 5
//     only when word2=0.
//   - word2 update on the 7->0 edge:
//     - word2 <= sampled two_byte if word2 was 0.
//     - word2 <= 0 if word2 was 1.
//   - PC update on the 7->0 edge, in priority order:
//     1. pop: PC <= stack[ptr-1]; ptr <= ptr-1 mod DEPTH.
//     2. pc_load & push: stack[ptr] <= PC+1; ptr <= ptr+1 mod DEPTH; PC <= load_addr.
//     3. pc_load: PC <= load_addr.
//     4. else: PC <= PC+1.
//   - push without pc_load is ignored. pop has priority over a simultaneous pc_load/push.
//   - PC+1 wraps modulo 2^ADDR_W (0xFFF -> 0x000).
//   - Decoder inputs are ignored outside cycles 5 and 7.
//   - Stack is circular, as on the 4004:
//     - 4th push overwrites the oldest entry.
//     - pop on an empty stack returns the wrapped entry.
//     - No blocking in either case.
//   - Occupancy counter (0..DEPTH) tracks overflow/underflow for stack_err only.
//   - Reset mid-frame aborts the frame: cycle and word2 return to 0 immediately.
// CONFIGURATION
//   FETCH_STACK_GUARD_EN
//   - Defined: stack_err sets on push at occupancy==DEPTH or pop at occupancy==0.
//     It stays set until rst.
//   - Undefined: stack_err tied 0 and the occupancy counter is not built.
//   - Stack data-path behaviour is identical either way.
// STRUCTURE
//   Shared package tb4004_pkg:
//   - cycle encodings CYC_A1..CYC_X3 (0..7).
//   - CYC_OPR=3, CYC_OPA=4, CYC_DEC=5, CYC_UPD=7.
//   - ADDR_W and STACK_DEPTH defaults.
//   Sub-module addr_stack:
//   - Holds the circular stack, ptr and optional guard.
//   - Ports: push, pop, din, dout, err.
//   fetch_ctrl keeps the cycle counter, PC and nibble capture.
// TESTING
//   - Reset, then run 3 frames with no decoder requests:
//     -> addr 0x000, 0x001, 0x002.
//     -> sync high only in cycle 0; word_valid only in cycle 5.
//   - ROM model bytes 0x40,0x12 at 0x000/0x001; two_byte=1 in frame 0
//     -> frame 1: word2=1, opr=4, opa=0, arg_hi=1, arg_lo=2.
//     -> frame 2: word2=0.
//   - PC=0x005, pc_load=1, push=1, load_addr=0x300 at cycle 7
//     -> next addr=0x300, stack top=0x006.
//     -> then pop at cycle 7 -> addr=0x006.
//   - 4 consecutive calls from 0x010,0x020,0x030,0x040 then 4 pops
//     -> return order 0x041,0x031,0x021,0x041 (wrap).
//     -> stack_err=1 only with FETCH_STACK_GUARD_EN.
//   - PC=0xFFF, no request -> next addr=0x000.
//   - pop and pc_load together -> pop wins.
//   - Assert rst at cycle 4 of a word2 frame -> cycle=0, word2=0, addr=RESET_PC.

Source files
------------

// File: rtl/tb4004_pkg.sv
// Shared definitions for the 4004 fetch path: machine-cycle encodings,
// the cycles that matter to fetch, and default widths.
package tb4004_pkg;

  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_STACK_DEPTH = 3;

  typedef enum logic [2:0] {
    CYC_A1 = 3'd0,
    CYC_A2 = 3'd1,
    CYC_A3 = 3'd2,
    CYC_M1 = 3'd3,
    CYC_M2 = 3'd4,
    CYC_X1 = 3'd5,
    CYC_X2 = 3'd6,
    CYC_X3 = 3'd7
  } cycle_t;

  localparam cycle_t CYC_OPR = CYC_M1;
  localparam cycle_t CYC_OPA = CYC_M2;
  localparam cycle_t CYC_DEC = CYC_X1;
  localparam cycle_t CYC_UPD = CYC_X3;

  // Machine cycles run freely and wrap from X3 back to A1.
  function automatic cycle_t next_cycle(input cycle_t c);
    return cycle_t'(c + 3'd1);
  endfunction

endpackage

// File: rtl/fetch_ctrl_addr_stack.sv
// Circular return-address stack of the 4004. Optional sticky overflow /
// underflow flag is built only when FETCH_STACK_GUARD_EN is defined.
module addr_stack
  import tb4004_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;

  // Pointer arithmetic modulo DEPTH; the top entry sits just below ptr.
  always_comb begin
    ptr_inc = PTR_ZERO;
    ptr_dec = PTR_ZERO;
    if (ptr == PTR_LAST) begin
      ptr_inc = PTR_ZERO;
    end else begin
      ptr_inc = ptr + PTR_ONE;
    end
    if (ptr == PTR_ZERO) begin
      ptr_dec = PTR_LAST;
    end else begin
      ptr_dec = ptr - PTR_ONE;
    end
    dout = mem[ptr_dec];
  end

  // Stack storage and pointer; pop wins over push, wraps never block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PTR_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {ADDR_W{1'b0}};
      end
    end else if (pop) begin
      ptr <= ptr_dec;
    end else if (push) begin
      mem[ptr] <= din;
      ptr      <= ptr_inc;
    end
  end

`ifdef FETCH_STACK_GUARD_EN
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ZERO = {OCC_W{1'b0}};
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  logic [OCC_W-1:0] occ;

  // Occupancy saturates at 0..DEPTH; any push on full or pop on empty latches err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= OCC_ZERO;
      err <= 1'b0;
    end else if (pop) begin
      if (occ == OCC_ZERO) begin
        err <= 1'b1;
      end else begin
        occ <= occ - OCC_ONE;
      end
    end else if (push) begin
      if (occ == OCC_FULL) begin
        err <= 1'b1;
      end else begin
        occ <= occ + OCC_ONE;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/fetch_ctrl.sv
// 4004 instruction-fetch sequencer: machine cycle, PC, nibble capture.
// Optional stack guard enabled by defining FETCH_STACK_GUARD_EN.
module fetch_ctrl
  import tb4004_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                STACK_DEPTH = DEF_STACK_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC    = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        nibble,
  input  logic              two_byte,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] addr,
  output logic [2:0]        cycle,
  output logic              sync,
  output logic [3:0]        opr,
  output logic [3:0]        opa,
  output logic [3:0]        arg_hi,
  output logic [3:0]        arg_lo,
  output logic              word2,
  output logic              word_valid,
  output logic              stack_err
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  cycle_t            cyc;
  cycle_t            cyc_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              two_byte_smp;
  logic              stack_push;
  logic              stack_pop;
  logic [ADDR_W-1:0] stack_dout;

  assign addr  = pc;
  assign cycle = cyc;

  // Machine-cycle state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= CYC_A1;
    end else begin
      cyc <= cyc_nxt;
    end
  end

  // Next cycle plus the frame-end PC / stack decision.
  always_comb begin
    cyc_nxt    = next_cycle(cyc);
    stack_push = 1'b0;
    stack_pop  = 1'b0;
    pc_nxt     = pc;
    if (cyc == CYC_UPD) begin
      if (pop) begin
        stack_pop = 1'b1;
        pc_nxt    = stack_dout;
      end else if (pc_load) begin
        stack_push = push;
        pc_nxt     = load_addr;
      end else begin
        pc_nxt = pc + PC_ONE;
      end
    end else begin
      pc_nxt = pc;
    end
  end

  // Program counter; only moves on the X3 -> A1 edge so addr is frame-stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_nxt;
    end
  end

  // Nibble capture, two_byte sampling and word2 sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opr          <= 4'h0;
      opa          <= 4'h0;
      arg_hi       <= 4'h0;
      arg_lo       <= 4'h0;
      word2        <= 1'b0;
      two_byte_smp <= 1'b0;
    end else begin
      case (cyc)
        CYC_OPR: begin
          if (word2) arg_hi <= nibble;
          else       opr    <= nibble;
        end
        CYC_OPA: begin
          if (word2) arg_lo <= nibble;
          else       opa    <= nibble;
        end
        CYC_DEC: begin
          if (!word2) two_byte_smp <= two_byte;
        end
        CYC_UPD: begin
          word2 <= word2 ? 1'b0 : two_byte_smp;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered strobes: each is set on the edge entering its cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= 1'b1;
      word_valid <= 1'b0;
    end else begin
      sync       <= (cyc == CYC_X3);
      word_valid <= (cyc == CYC_M2);
    end
  end

  addr_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (stack_push),
    .pop  (stack_pop),
    .din  (pc + PC_ONE),
    .dout (stack_dout),
    .err  (stack_err)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: frame-level reference model feeds an
// expectation queue, a negedge monitor checks every cycle and every word.
module tb_fetch_ctrl;
  import tb4004_pkg::*;

  localparam int         AW  = 12;
  localparam logic [11:0] RPC = 12'h000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  nibble = 4'h0;
  logic        two_byte = 1'b0;
  logic        pc_load = 1'b0;
  logic [11:0] load_addr = 12'h000;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [11:0] addr;
  logic [2:0]  cycle;
  logic        sync;
  logic [3:0]  opr, opa, arg_hi, arg_lo;
  logic        word2, word_valid, stack_err;

  fetch_ctrl #(.ADDR_W(AW), .STACK_DEPTH(3), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .nibble(nibble), .two_byte(two_byte),
    .pc_load(pc_load), .load_addr(load_addr), .push(push), .pop(pop),
    .addr(addr), .cycle(cycle), .sync(sync), .opr(opr), .opa(opa),
    .arg_hi(arg_hi), .arg_lo(arg_lo), .word2(word2),
    .word_valid(word_valid), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr; int word2; int opr; int opa; int ahi; int alo; int err;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic [7:0] rom [4096];

`ifdef FETCH_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // Reference model state, one step per frame.
  int m_pc, m_word2, m_ptr, m_occ, m_err;
  int m_stk [3];
  int m_opr, m_opa, m_ahi, m_alo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = int'(RPC); m_word2 = 0; m_ptr = 0; m_occ = 0; m_err = 0;
    for (int i = 0; i < 3; i++) m_stk[i] = 0;
    m_opr = 0; m_opa = 0; m_ahi = 0; m_alo = 0;
  endfunction

  // Expected word of this frame, then the frame-end state change.
  function automatic void model_frame(input bit tb, input bit ld, input bit ps,
                                      input bit pp, input int la);
    exp_t e;
    int   b;
    b = int'(rom[m_pc]);
    if (m_word2 == 0) begin m_opr = b / 16; m_opa = b % 16; end
    else              begin m_ahi = b / 16; m_alo = b % 16; end
    e.addr = m_pc; e.word2 = m_word2; e.opr = m_opr; e.opa = m_opa;
    e.ahi = m_ahi; e.alo = m_alo; e.err = m_err;
    q.push_back(e);
    if (pp) begin
      m_ptr = (m_ptr + 2) % 3;
      m_pc  = m_stk[m_ptr];
      if (m_occ == 0) m_err = GUARD ? 1 : 0; else m_occ--;
    end else if (ld) begin
      if (ps) begin
        m_stk[m_ptr] = (m_pc + 1) % 4096;
        m_ptr = (m_ptr + 1) % 3;
        if (m_occ == 3) m_err = GUARD ? 1 : 0; else m_occ++;
      end
      m_pc = la;
    end else begin
      m_pc = (m_pc + 1) % 4096;
    end
    m_word2 = (m_word2 != 0) ? 0 : int'(tb);
  endfunction

  // Drive n cycles from cycle 0; decoder inputs are noise outside cycles 5/7.
  task automatic drive_cycles(input bit tb, input bit ld, input bit ps, input bit pp,
                              input logic [11:0] la, input int n);
    logic [7:0] byte_v;
    for (int c = 0; c < n; c++) begin
      byte_v    = rom[addr];
      nibble    = (c == 3) ? byte_v[7:4] : (c == 4) ? byte_v[3:0] : 4'($urandom);
      two_byte  = (c == 5) ? tb : 1'($urandom);
      pc_load   = (c == 7) ? ld : 1'($urandom);
      push      = (c == 7) ? ps : 1'($urandom);
      pop       = (c == 7) ? pp : 1'($urandom);
      load_addr = (c == 7) ? la : 12'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input bit tb, input bit ld, input bit ps, input bit pp,
                           input logic [11:0] la);
    model_frame(tb, ld, ps, pp, int'(la));
    drive_cycles(tb, ld, ps, pp, la, 8);
  endtask

  // Called just after a posedge; returns with DUT in cycle 0 after release.
  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: cycle strobes every clock, scoreboard pop on each word_valid.
  initial begin
    int   cyc_m;
    exp_t e;
    cyc_m = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc_m = 0;
      end else begin
        chk("cycle", 32'(cycle), 32'(cyc_m));
        chk("sync", 32'(sync), 32'(cyc_m == 0));
        chk("word_valid", 32'(word_valid), 32'(cyc_m == 5));
        if (word_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_word", 32'(1), 32'(0));
          end else begin
            e = q.pop_front();
            chk("addr", 32'(addr), 32'(e.addr));
            chk("word2", 32'(word2), 32'(e.word2));
            chk("opr", 32'(opr), 32'(e.opr));
            chk("opa", 32'(opa), 32'(e.opa));
            chk("arg_hi", 32'(arg_hi), 32'(e.ahi));
            chk("arg_lo", 32'(arg_lo), 32'(e.alo));
            chk("stack_err", 32'(stack_err), 32'(e.err));
          end
        end
        cyc_m = (cyc_m + 1) % 8;
      end
    end
  end

  initial begin
    bit          tb, ld, ps, pp;
    logic [11:0] la;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h40;
    rom[1] = 8'h12;
    model_reset();
    #1;
    chk("rst_cycle", 32'(cycle), 32'(0));
    chk("rst_addr", 32'(addr), 32'(RPC));
    chk("rst_word2", 32'(word2), 32'(0));
    chk("rst_opr", 32'(opr), 32'(0));
    chk("rst_stack_err", 32'(stack_err), 32'(0));
    @(posedge clk);
    #1;
    do_reset();

    // Free-running frames: 0x000, 0x001, 0x002.
    repeat (3) run_frame(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    // Two-word instruction 0x40 0x12.
    do_reset();
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    // Call from 0x005 to 0x300, then return to 0x006.
    do_reset();
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 12'h005);
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, 12'h300);
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    // Four nested calls overflow the 3-entry stack, four returns wrap.
    do_reset();
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 12'h010);
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, 12'h020);
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, 12'h030);
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, 12'h040);
    run_frame(1'b0, 1'b1, 1'b1, 1'b0, 12'h050);
    repeat (4) run_frame(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    // PC wrap and pop-over-load priority.
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    run_frame(1'b0, 1'b1, 1'b1, 1'b1, 12'h777);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    // Randomized frames against the model.
    do_reset();
    for (int f = 0; f < 200; f++) begin
      pp = ($urandom_range(0, 5) == 0);
      ld = ($urandom_range(0, 3) == 0);
      ps = ld && ($urandom_range(0, 1) == 1);
      tb = ($urandom_range(0, 2) == 0);
      la = 12'($urandom);
      run_frame(tb, ld, ps, pp, la);
    end

    // Reset in cycle 4 of a second-word frame.
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    drive_cycles(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 4);
    chk("pre_rst_cycle", 32'(cycle), 32'(4));
    chk("pre_rst_word2", 32'(word2), 32'(m_word2));
    rst = 1'b1;
    #1;
    chk("mid_rst_cycle", 32'(cycle), 32'(0));
    chk("mid_rst_word2", 32'(word2), 32'(0));
    chk("mid_rst_addr", 32'(addr), 32'(RPC));
    do_reset();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
